// File: rtl/exec_pkg.sv
// exec_pkg: shared op encodings, selector fields and FSM states for the execute stage
package exec_pkg;
  localparam int NOPS = 10;
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR = 3;
  localparam int OP_XOR = 4;
  localparam int OP_NOT = 5;
  localparam int OP_SHL = 6;
  localparam int OP_SHR = 7;
  localparam int OP_PASSB = 8;
  localparam int OP_MUL = 9;
  localparam int SEL_EXT_BIT = 5;
  localparam int SEL_PORT_BIT = 5;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WB} state_t;
  function automatic logic is_onehot(input logic [NOPS-1:0] v);
    return (v != '0) && ((v & (v - NOPS'(1))) == '0);
  endfunction
endpackage

// File: rtl/exec_mul_serial.sv
// exec_mul_serial: shift-add multiplier, one partial product per cycle
module exec_mul_serial #(
  parameter int DATA_W = 32,
  parameter int CYCLES = DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   prod
);
  localparam int CW = $clog2(CYCLES + 1);
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [CW-1:0] cnt;
  // done marks the cycle whose edge retires the last iteration
  assign done = busy && (cnt == CW'(1));
  // load operands on start, then accumulate one multiplier bit per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt <= '0;
      prod <= '0;
      mcand <= '0;
      mplier <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= CW'(CYCLES);
      prod <= '0;
      mcand <= {{DATA_W{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      prod <= mplier[0] ? prod + mcand : prod;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt - CW'(1);
      busy <= cnt != CW'(1);
    end
  end
endmodule

// File: rtl/exec_stage.sv
// exec_stage: execute/writeback stage; EXEC_MUL_EN enables the serial multiplier
module exec_stage
  import exec_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG = 32,
  parameter int MUL_CYCLES = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              ready,
  input  logic [9:0]        aluCtrl_,
  input  logic [DATA_W-1:0] imm_,
  input  logic              imm_en_,
  input  logic [5:0]        selA_,
  input  logic [4:0]        selB_,
  input  logic [5:0]        selOut_,
  input  logic [DATA_W-1:0] ext_in,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_addr,
  output logic              out_valid,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              illegal_op,
  input  logic [4:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);
`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  state_t state, state_nx;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] op_a, op_b, res, wr_val;
  logic [DATA_W:0] sum;
  logic [2*DATA_W-1:0] mul_prod;
  logic [5:0] dest_q, wr_sel;
  logic accept, legal, arith, res_c, wr_en, wr_c, mul_go, mul_busy, mul_done;
  assign ready = (state == S_IDLE) && !rst;
  assign accept = in_valid && ready;
  assign legal = is_onehot(aluCtrl_) && (MUL_EN || !aluCtrl_[OP_MUL]);
  assign mul_go = accept && legal && aluCtrl_[OP_MUL];
  assign op_a = selA_[SEL_EXT_BIT] ? ext_in : regs[selA_[4:0]];
  assign op_b = imm_en_ ? imm_ : regs[selB_];
  assign dbg_data = (dbg_sel == 5'd0) ? '0 : regs[dbg_sel];
  assign arith = aluCtrl_[OP_ADD] || aluCtrl_[OP_SUB];
  assign sum = {1'b0, op_a} + {1'b0, aluCtrl_[OP_SUB] ? ~op_b : op_b} + (DATA_W+1)'(aluCtrl_[OP_SUB]);
`ifdef EXEC_MUL_EN
  exec_mul_serial #(.DATA_W(DATA_W), .CYCLES(MUL_CYCLES)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(mul_go),
    .a(op_a),
    .b(op_b),
    .busy(mul_busy),
    .done(mul_done),
    .prod(mul_prod)
  );
`else
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif
  // single-cycle ALU result; ops are one-hot so a priority chain is exact
  always_comb begin
    res = '0;
    res = arith ? sum[DATA_W-1:0] :
          aluCtrl_[OP_AND] ? op_a & op_b :
          aluCtrl_[OP_OR] ? op_a | op_b :
          aluCtrl_[OP_XOR] ? op_a ^ op_b :
          aluCtrl_[OP_NOT] ? ~op_a :
          aluCtrl_[OP_SHL] ? op_a << op_b[4:0] :
          aluCtrl_[OP_SHR] ? op_a >> op_b[4:0] : op_b;
    res_c = arith && sum[DATA_W];
  end
  // writeback source: multiplier result in WB, otherwise the accepted single-cycle op
  always_comb begin
    wr_en = (state == S_WB) || (accept && legal && !aluCtrl_[OP_MUL]);
    wr_sel = (state == S_WB) ? dest_q : selOut_;
    wr_val = (state == S_WB) ? mul_prod[DATA_W-1:0] : res;
    wr_c = (state == S_WB) ? |mul_prod[2*DATA_W-1:DATA_W] : res_c;
  end
  // next state: IDLE -> MUL on a multiply, MUL -> WB on the last iteration, WB -> IDLE
  always_comb begin
    state_nx = state;
    state_nx = (state == S_IDLE) ? (mul_go ? S_MUL : S_IDLE) :
               (state == S_MUL) ? (mul_done ? S_WB : (mul_busy ? S_MUL : S_IDLE)) : S_IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= state_nx;
  end
  // register file, output port, flags and strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      out_data <= '0;
      out_addr <= '0;
      out_valid <= 1'b0;
      illegal_op <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      dest_q <= '0;
    end else begin
      out_valid <= wr_en && wr_sel[SEL_PORT_BIT];
      illegal_op <= accept && !legal;
      if (mul_go) dest_q <= selOut_;
      if (wr_en) begin
        flag_z <= wr_val == '0;
        flag_n <= wr_val[DATA_W-1];
        flag_c <= wr_c;
        if (wr_sel[SEL_PORT_BIT]) begin
          out_data <= wr_val;
          out_addr <= wr_sel[4:0];
        end else if (wr_sel[4:0] != 5'd0) begin
          regs[wr_sel[4:0]] <= wr_val;
        end
      end
    end
  end
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed vector bench for exec_stage
module tb_exec_stage;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, imm_en_ = 1'b0;
  logic [9:0] aluCtrl_ = '0;
  logic [31:0] imm_ = '0, ext_in = '0;
  logic [5:0] selA_ = '0, selOut_ = '0;
  logic [4:0] selB_ = '0, dbg_sel = '0;
  logic ready, out_valid, flag_z, flag_n, flag_c, illegal_op;
  logic [31:0] out_data, dbg_data;
  logic [4:0] out_addr;
  int n_cmp = 0, n_bad = 0;

  exec_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ready(ready),
    .aluCtrl_(aluCtrl_), .imm_(imm_), .imm_en_(imm_en_), .selA_(selA_),
    .selB_(selB_), .selOut_(selOut_), .ext_in(ext_in), .out_data(out_data),
    .out_addr(out_addr), .out_valid(out_valid), .flag_z(flag_z), .flag_n(flag_n),
    .flag_c(flag_c), .illegal_op(illegal_op), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] alu;
    logic [31:0] imm;
    logic ien;
    logic [5:0] sa;
    logic [4:0] sb;
    logic [5:0] so;
    logic [31:0] ext;
    logic [31:0] exp;
    logic [2:0] znc;
  } vec_t;

  vec_t tv[16];

  function automatic vec_t mk(logic [9:0] alu, logic [31:0] imm, logic ien, logic [5:0] sa,
                              logic [4:0] sb, logic [5:0] so, logic [31:0] ext,
                              logic [31:0] exp, logic [2:0] znc);
    vec_t v;
    v.alu = alu; v.imm = imm; v.ien = ien; v.sa = sa; v.sb = sb;
    v.so = so; v.ext = ext; v.exp = exp; v.znc = znc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [9:0] alu, input logic [31:0] imm, input logic ien,
                       input logic [5:0] sa, input logic [4:0] sb, input logic [5:0] so,
                       input logic [31:0] ext);
    aluCtrl_ = alu; imm_ = imm; imm_en_ = ien; selA_ = sa; selB_ = sb; selOut_ = so; ext_in = ext;
    in_valid = 1'b1;
  endtask

  task automatic rd(input logic [4:0] r, output logic [31:0] v);
    dbg_sel = r;
    #1;
    v = dbg_data;
  endtask

  task automatic issue1(input logic [9:0] alu, input logic [31:0] imm, input logic ien,
                        input logic [5:0] sa, input logic [4:0] sb, input logic [5:0] so,
                        input logic [31:0] ext);
    @(negedge clk);
    drive(alu, imm, ien, sa, sb, so, ext);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    int n;
    tv[0]  = mk(10'h100, 32'd5,        1, 6'd1,    5'd0, 6'd1,  32'd0,        32'd5,        3'b000);
    tv[1]  = mk(10'h001, 32'd7,        1, 6'd1,    5'd0, 6'd2,  32'd0,        32'd12,       3'b000);
    tv[2]  = mk(10'h002, 32'd0,        0, 6'd2,    5'd2, 6'd4,  32'd0,        32'd0,        3'b101);
    tv[3]  = mk(10'h100, 32'd3,        1, 6'd0,    5'd0, 6'd5,  32'd0,        32'd3,        3'b000);
    tv[4]  = mk(10'h100, 32'd5,        1, 6'd0,    5'd0, 6'd6,  32'd0,        32'd5,        3'b000);
    tv[5]  = mk(10'h002, 32'd0,        0, 6'd5,    5'd6, 6'd7,  32'd0,        32'hFFFFFFFE, 3'b010);
    tv[6]  = mk(10'h004, 32'hFF00,     1, 6'h20,   5'd0, 6'd8,  32'hF0F0,     32'hF000,     3'b000);
    tv[7]  = mk(10'h008, 32'h000F,     1, 6'd8,    5'd0, 6'd9,  32'd0,        32'hF00F,     3'b000);
    tv[8]  = mk(10'h010, 32'hFFFF,     1, 6'd9,    5'd0, 6'd10, 32'd0,        32'h0FF0,     3'b000);
    tv[9]  = mk(10'h020, 32'd0,        0, 6'd10,   5'd0, 6'd11, 32'd0,        32'hFFFFF00F, 3'b010);
    tv[10] = mk(10'h040, 32'd4,        1, 6'd1,    5'd0, 6'd12, 32'd0,        32'h50,       3'b000);
    tv[11] = mk(10'h080, 32'd2,        1, 6'd12,   5'd0, 6'd13, 32'd0,        32'h14,       3'b000);
    tv[12] = mk(10'h001, 32'd1,        1, 6'h20,   5'd0, 6'd14, 32'hFFFFFFFF, 32'd0,        3'b101);
    tv[13] = mk(10'h100, 32'd9,        1, 6'd0,    5'd0, 6'd0,  32'd0,        32'd0,        3'b000);
    tv[14] = mk(10'h040, 32'd31,       1, 6'd1,    5'd0, 6'd15, 32'd0,        32'h80000000, 3'b010);
    tv[15] = mk(10'h002, 32'd0,        0, 6'd6,    5'd5, 6'd17, 32'd0,        32'd2,        3'b001);

    // reset state
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    chk("rst_flags", {29'd0, flag_z, flag_n, flag_c}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_strobes", {30'd0, out_valid, illegal_op}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", {31'd0, ready}, 32'd1);

    // single-cycle vector table
    for (int i = 0; i < 16; i++) begin
      issue1(tv[i].alu, tv[i].imm, tv[i].ien, tv[i].sa, tv[i].sb, tv[i].so, tv[i].ext);
      rd(tv[i].so[4:0], v);
      chk($sformatf("vec%0d_data", i), v, tv[i].exp);
      chk($sformatf("vec%0d_znc", i), {29'd0, flag_z, flag_n, flag_c}, {29'd0, tv[i].znc});
      chk($sformatf("vec%0d_ready", i), {31'd0, ready}, 32'd1);
    end

    // illegal ops: two-hot and all-zero leave flags and registers alone
    for (int k = 0; k < 2; k++) begin
      issue1(k == 0 ? 10'h003 : 10'h000, 32'h77, 1, 6'd0, 5'd0, 6'd1, 32'd0);
      chk("illegal_strobe", {31'd0, illegal_op}, 32'd1);
      chk("illegal_flags", {29'd0, flag_z, flag_n, flag_c}, 32'd1);
      rd(5'd1, v);
      chk("illegal_r1", v, 32'd5);
      @(negedge clk);
      chk("illegal_strobe_drop", {31'd0, illegal_op}, 32'd0);
    end

    // port write
    issue1(10'h100, 32'hABCD, 1, 6'd0, 5'd0, 6'h25, 32'd0);
    chk("port_valid", {31'd0, out_valid}, 32'd1);
    chk("port_addr", {27'd0, out_addr}, 32'd5);
    chk("port_data", out_data, 32'hABCD);
    rd(5'd5, v);
    chk("port_r5_kept", v, 32'd3);
    @(negedge clk);
    chk("port_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("port_data_hold", out_data, 32'hABCD);

`ifdef EXEC_MUL_EN
    // MUL 6*7 -> r3 with a second instruction held during the stall
    @(negedge clk);
    drive(10'h200, 32'd7, 1, 6'h20, 5'd0, 6'd3, 32'd6);
    @(posedge clk);
    @(negedge clk);
    drive(10'h001, 32'd1, 1, 6'd16, 5'd0, 6'd16, 32'd0);
    n = 0;
    while (!ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("mul_stall_cycles", n, 32'd33);
    rd(5'd3, v);
    chk("mul_r3", v, 32'd42);
    chk("mul_znc", {29'd0, flag_z, flag_n, flag_c}, 32'd0);
    rd(5'd16, v);
    chk("held_not_early", v, 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rd(5'd16, v);
    chk("held_once", v, 32'd1);
    // MUL with a nonzero high half: 2^16 * 2^16
    @(negedge clk);
    drive(10'h200, 32'h10000, 1, 6'h20, 5'd0, 6'd18, 32'h10000);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("mul2_stall_cycles", n, 32'd33);
    rd(5'd18, v);
    chk("mul2_low", v, 32'd0);
    chk("mul2_znc", {29'd0, flag_z, flag_n, flag_c}, 32'b101);
    // reset 10 cycles into a MUL aborts the writeback
    @(negedge clk);
    drive(10'h200, 32'd7, 1, 6'h20, 5'd0, 6'd20, 32'd6);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready_in_rst", {31'd0, ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready_after", {31'd0, ready}, 32'd1);
    chk("abort_flags", {29'd0, flag_z, flag_n, flag_c}, 32'd0);
    chk("abort_out", out_data, 32'd0);
    repeat (40) @(negedge clk);
    rd(5'd20, v);
    chk("abort_no_wb", v, 32'd0);
    rd(5'd1, v);
    chk("abort_r1_cleared", v, 32'd0);
    chk("abort_ready_idle", {31'd0, ready}, 32'd1);
`else
    // without the multiplier a MUL opcode is illegal
    issue1(10'h200, 32'd7, 1, 6'h20, 5'd0, 6'd3, 32'd6);
    chk("mul_illegal", {31'd0, illegal_op}, 32'd1);
    chk("mul_ready", {31'd0, ready}, 32'd1);
    rd(5'd3, v);
    chk("mul_no_write", v, 32'd0);
    // reset clears registers and ready follows rst only
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst2_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst2_ready_after", {31'd0, ready}, 32'd1);
    rd(5'd1, v);
    chk("rst2_r1_cleared", v, 32'd0);
    chk("rst2_out", out_data, 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute/writeback stage directly downstream of the decode pipeline latch.
- Consumes the latched ALU control, immediate, operand selectors and destination selector.
- Reads operands from an internal register file or an external input bus, computes the result, and writes it back to a register or to an output port.
- Drives the latch enable (ready) so multi-cycle operations stall decode.

Parameters:
DATA_W, 32, datapath and immediate width
NREG, 32, register count (index width 5; r0 hardwired zero)
MUL_CYCLES, DATA_W, iterations of the serial multiplier

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  latched instruction is valid
ready  out  1  stage can accept; drives latch en
aluCtrl_  in  10  one-hot op: [0]ADD [1]SUB [2]AND [3]OR [4]XOR [5]NOT [6]SHL [7]SHR [8]PASSB [9]MUL
imm_  in  DATA_W  immediate
imm_en_  in  1  operand B = imm_
selA_  in  6  [5]=1: A=ext_in, else A=reg[selA_[4:0]]
selB_  in  5  B register index
selOut_  in  6  [5]=1: output port selOut_[4:0], else register selOut_[4:0]
ext_in  in  DATA_W  external operand bus
out_data  out  DATA_W  output port data
out_addr  out  5  output port address
out_valid  out  1  one-cycle strobe on port write
flag_z, flag_n, flag_c  out  1 each  registered flags
illegal_op  out  1  one-cycle strobe on rejected op
dbg_sel  in  5  debug register read index
dbg_data  out  DATA_W  reg[dbg_sel], combinational

Behaviour:
- Reset (synchronous, active-high): all registers, out_data, out_addr and flags cleared to 0; out_valid=0; illegal_op=0; FSM to IDLE; ready=0 while rst=1.
- Accept: in_valid && ready at a posedge.
- FSM states: IDLE, MUL, WB. ready=1 only in IDLE with rst=0.
- Single-cycle ops: result written on the accepting edge. The next accepted instruction sees the new value, so no hazard logic is needed.
- Reads: reg[0] reads 0; writes to r0 are discarded but flags still update.
- Operand A = selA_[5] ? ext_in : reg[selA_[4:0]].
- Operand B = imm_en_ ? imm_ : reg[selB_].
- Arithmetic, all modulo 2^DATA_W:
  - ADD: A+B; C = carry-out.
  - SUB: A+~B+1; C = carry-out, i.e. 1 when A>=B unsigned.
  - Logic ops, NOT (~A), PASSB: C=0.
  - SHL/SHR: logical shift of A by B[4:0]; C=0.
- Flags: Z = (result==0); N = result[DATA_W-1]. Updated on every successful op; unchanged on an illegal op.
- Destination:
  - selOut_[5]=0 writes reg[selOut_[4:0]].
  - selOut_[5]=1 writes out_data/out_addr and pulses out_valid for exactly one cycle; registers are unchanged.
- Illegal op (aluCtrl_ not exactly one-hot, including all-zero): pulse illegal_op 1 cycle, no write, no flag change, stay IDLE.
- MUL:
  - On accept, capture A, B and destination; IDLE->MUL.
  - Shift-add for MUL_CYCLES cycles, then MUL->WB.
  - WB writes the low DATA_W bits to the destination; C = |high DATA_W bits; Z/N from the low part; then WB->IDLE.
  - ready=0 for MUL_CYCLES+1 cycles after accept.
- in_valid=0: no state change. in_valid is ignored while ready=0.
- rst during MUL or WB aborts the operation: no writeback, next cycle IDLE with cleared state.

Optional Feature:
EXEC_MUL_EN
- Defined: serial multiplier and MUL/WB states present as above.
- Undefined: no multiplier logic; aluCtrl_[9] is treated as illegal (illegal_op pulse, no write); ready depends only on rst.

Decomposition:
- Package exec_pkg: op bit-position constants (OP_ADD..OP_MUL), FSM state enum, selector field constants (SEL_EXT_BIT=5, SEL_PORT_BIT=5).
- Sub-module exec_mul_serial: start/busy/done handshake, DATA_W x DATA_W -> 2*DATA_W shift-add; instantiated only under EXEC_MUL_EN.

Test Plan:
1. PASSB imm=5 -> r1; then ADD selA=1, imm=7, selOut=2 -> dbg r2=12, Z=0, C=0, ready stays 1.
2. SUB r2-r2 (selA=2, selB=2) -> result 0, Z=1, C=1; SUB 3-5 -> 0xFFFFFFFE, N=1, C=0.
3. MUL 6*7 -> r3: ready=0 exactly 33 cycles; r3=42, C=0; second instruction held until ready=1 and then executes once.
4. PASSB imm=9 -> selOut=0 -> dbg r0 reads 0; selOut=6'h25 with imm=0xABCD -> out_valid 1 cycle, out_addr=5, out_data=0xABCD, registers unchanged.
5. aluCtrl=10'h003 or 10'h000 -> illegal_op 1 cycle, flags and registers unchanged.
6. Assert rst 10 cycles into MUL -> no writeback to destination, all outputs 0; ready=1 the cycle after rst drops.
